// File: rtl/alu_pkg.sv
// Shared ALU definitions: 6-bit control codes, default XLEN, the muldiv
// state encoding and small decode helpers used by the EX-stage units.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 32;

  // Single-cycle ALU operations
  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_SUB    = 6'b000001;
  localparam logic [5:0] ALU_AND    = 6'b000010;
  localparam logic [5:0] ALU_OR     = 6'b000011;
  localparam logic [5:0] ALU_XOR    = 6'b000100;
  localparam logic [5:0] ALU_SLL    = 6'b000101;
  localparam logic [5:0] ALU_SRL    = 6'b000110;
  localparam logic [5:0] ALU_SRA    = 6'b000111;
  localparam logic [5:0] ALU_SLT    = 6'b100000;
  localparam logic [5:0] ALU_SLTU   = 6'b100001;
  localparam logic [5:0] ALU_LUI    = 6'b100010;
  localparam logic [5:0] ALU_PASSB  = 6'b100011;

  // Branch comparisons
  localparam logic [5:0] ALU_BEQ    = 6'b001000;
  localparam logic [5:0] ALU_BNE    = 6'b001001;
  localparam logic [5:0] ALU_BLT    = 6'b001100;
  localparam logic [5:0] ALU_BGE    = 6'b001101;
  localparam logic [5:0] ALU_BLTU   = 6'b001110;
  localparam logic [5:0] ALU_BGEU   = 6'b001111;

  // Atomic memory operations
  localparam logic [5:0] ALU_AMOSWAP = 6'b011000;
  localparam logic [5:0] ALU_AMOADD  = 6'b011001;
  localparam logic [5:0] ALU_AMOAND  = 6'b011010;
  localparam logic [5:0] ALU_AMOOR   = 6'b011011;
  localparam logic [5:0] ALU_AMOXOR  = 6'b011100;
  localparam logic [5:0] ALU_AMOMIN  = 6'b011101;
  localparam logic [5:0] ALU_AMOMAX  = 6'b011110;
  localparam logic [5:0] ALU_AMOMINU = 6'b011111;

  // RV32M operations
  localparam logic [5:0] ALU_MUL    = 6'b010000;
  localparam logic [5:0] ALU_MULH   = 6'b010001;
  localparam logic [5:0] ALU_MULHSU = 6'b010010;
  localparam logic [5:0] ALU_MULHU  = 6'b010011;
  localparam logic [5:0] ALU_DIV    = 6'b010100;
  localparam logic [5:0] ALU_DIVU   = 6'b010101;
  localparam logic [5:0] ALU_REM    = 6'b010110;
  localparam logic [5:0] ALU_REMU   = 6'b010111;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIX,
    MD_DONE
  } md_state_t;

  function automatic logic is_muldiv(input logic [5:0] code);
    return code[5:3] == 3'b010;
  endfunction

  function automatic logic is_div(input logic [5:0] code);
    return code[2];
  endfunction

  // rs1 is treated as signed for mul, mulh, mulhsu, div, rem
  function automatic logic signed_a(input logic [2:0] op);
    return op[2] ? ~op[0] : (op[1:0] != 2'b11);
  endfunction

  // rs2 is treated as signed for mul, mulh, div, rem
  function automatic logic signed_b(input logic [2:0] op);
    return op[2] ? ~op[0] : ~op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the muldiv datapath. Multiply: conditional add of the
// multiplicand into the upper half, then shift the 2*XLEN accumulator right.
// Divide: shift {remainder, quotient} left, trial-subtract the divisor and
// keep the difference when it is non-negative.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] acc_next,
  output logic              q_bit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_shift;
  logic [XLEN:0] diff;

  // Single shift-add or restoring shift-subtract step
  always_comb begin
    sum       = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    rem_shift = acc[2*XLEN-1:XLEN-1];
    diff      = rem_shift - {1'b0, operand};
    q_bit     = 1'b0;
    if (div_mode) begin
      q_bit    = ~diff[XLEN];
      // quotient bit slot is left clear; the caller merges q_bit in
      acc_next = {(q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execution unit (mul/mulh/mulhsu/mulhu/div/divu/rem/remu).
// Works on operand magnitudes and applies the sign fix-up in FIX.
// Build option MULDIV_FAST_MUL_EN: multiplies use a combinational product
// registered in FIX instead of the iterative MUL state.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int unsigned      CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

`ifdef MULDIV_FAST_MUL_EN
  localparam logic FAST_MUL = 1'b1;
`else
  localparam logic FAST_MUL = 1'b0;
`endif

  md_state_t         state;
  md_state_t         state_next;
  logic [CNT_W-1:0]  count;
  logic [2:0]        op;
  logic              neg_a;
  logic              neg_b;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   a_raw;
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] acc;

  logic [2*XLEN-1:0] step_acc;
  logic              step_q;

  logic              accept;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              in_zero;
  logic              in_ovf;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_val;

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .acc      (acc),
    .operand  (operand),
    .div_mode (op[2]),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Accept-time decode: signs, magnitudes and divide special cases
  always_comb begin
    accept  = (state == MD_IDLE) && start && is_muldiv(alu_ctrl);
    a_neg   = signed_a(alu_ctrl[2:0]) && op_a[XLEN-1];
    b_neg   = signed_b(alu_ctrl[2:0]) && op_b[XLEN-1];
    a_mag   = a_neg ? -op_a : op_a;
    b_mag   = b_neg ? -op_b : op_b;
    in_zero = is_div(alu_ctrl) && (op_b == '0);
    in_ovf  = is_div(alu_ctrl) && !alu_ctrl[0] &&
              (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: begin
        if (accept) begin
          if (is_div(alu_ctrl)) begin
            state_next = (in_zero || in_ovf) ? MD_FIX : MD_DIV;
          end else begin
            state_next = FAST_MUL ? MD_FIX : MD_MUL;
          end
        end
      end
      MD_MUL, MD_DIV: begin
        if (count == CNT_LAST) state_next = MD_FIX;
      end
      MD_FIX:  state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    busy  = (state == MD_MUL) || (state == MD_DIV) || (state == MD_FIX);
    valid = (state == MD_DONE);
  end

  // Sign fix-up and result selection
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod = {{XLEN{1'b0}}, operand} * {{XLEN{1'b0}}, acc[XLEN-1:0]};
`else
    prod = acc;
`endif
    if (neg_a ^ neg_b) prod = -prod;
    quo = acc[XLEN-1:0];
    if (neg_a ^ neg_b) quo = -quo;
    rem = acc[2*XLEN-1:XLEN];
    if (neg_a) rem = -rem;
    if (div_zero) begin
      quo = '1;
      rem = a_raw;
    end else if (div_ovf) begin
      quo = a_raw;
      rem = '0;
    end
    case (op)
      3'b000:                 fix_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = quo;
      default:                fix_val = rem;
    endcase
  end

  // State, operand latches, iteration accumulator and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MD_IDLE;
      count    <= '0;
      op       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      a_raw    <= '0;
      operand  <= '0;
      acc      <= '0;
      result   <= '0;
    end else begin
      state <= state_next;
      case (state)
        MD_IDLE: begin
          if (accept) begin
            op       <= alu_ctrl[2:0];
            neg_a    <= a_neg;
            neg_b    <= b_neg;
            div_zero <= in_zero;
            div_ovf  <= in_ovf;
            a_raw    <= op_a;
            count    <= '0;
            if (is_div(alu_ctrl)) begin
              operand <= b_mag;
              acc     <= {{XLEN{1'b0}}, a_mag};
            end else begin
              operand <= a_mag;
              acc     <= {{XLEN{1'b0}}, b_mag};
            end
          end
        end
        MD_MUL, MD_DIV: begin
          acc   <= step_acc | {{(2*XLEN-1){1'b0}}, step_q};
          count <= count + 1'b1;
        end
        MD_FIX: result <= fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] C_MUL    = 6'b010000;
  localparam logic [5:0] C_MULH   = 6'b010001;
  localparam logic [5:0] C_MULHSU = 6'b010010;
  localparam logic [5:0] C_MULHU  = 6'b010011;
  localparam logic [5:0] C_DIV    = 6'b010100;
  localparam logic [5:0] C_DIVU   = 6'b010101;
  localparam logic [5:0] C_REM    = 6'b010110;
  localparam logic [5:0] C_REMU   = 6'b010111;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [5:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(
    .XLEN(XLEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .valid    (valid),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RV32M semantics in 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [5:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] as;
    logic signed [31:0] bs;
    logic signed [63:0] as64;
    logic signed [63:0] bs64;
    logic [63:0]        bu64;
    logic [63:0]        au64;
    logic [63:0]        p;
    logic               ovf;
    as   = a;
    bs   = b;
    as64 = as;
    bs64 = bs;
    au64 = {32'b0, a};
    bu64 = {32'b0, b};
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p    = '0;
    case (code[2:0])
      3'd0: begin p = as64 * bs64; return p[31:0]; end
      3'd1: begin p = as64 * bs64; return p[63:32]; end
      3'd2: begin p = as64 * bu64; return p[63:32]; end
      3'd3: begin p = au64 * bu64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return as / bs;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return as % bs;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the accept cycle to the valid cycle
  function automatic int exp_lat(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    if (code[2]) begin
      if (b == 0) return 2;
      if (!code[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 2;
`else
    return 34;
`endif
  endfunction

  // Issue one op at the current negedge (unit idle), wait for valid, check.
  // pulse_at: cycle index at which a stray start is pulsed (0 = none).
  // poke_done: assert start during the DONE cycle and confirm it is dropped.
  task automatic run_op(input string name, input logic [5:0] code, input logic [31:0] a,
                        input logic [31:0] b, input int pulse_at, input bit poke_done);
    logic [31:0] exp;
    int          lat;
    int          cyc;
    int          nb;
    bit          seen;
    exp      = ref_result(code, a, b);
    lat      = exp_lat(code, a, b);
    start    = 1'b1;
    alu_ctrl = code;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    start    = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    alu_ctrl = C_MUL | 6'($urandom_range(0, 7));
    cyc  = 1;
    nb   = 0;
    seen = 1'b0;
    while (!seen && cyc <= 100) begin
      if (valid) begin
        seen = 1'b1;
      end else begin
        if (busy) nb++;
        if (cyc == pulse_at) begin
          start    = 1'b1;
          alu_ctrl = C_MULHU;
          op_a     = $urandom;
          op_b     = $urandom;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check({name, "/valid_seen"}, 64'(seen), 64'd1);
    check({name, "/result"}, result, exp);
    check({name, "/latency"}, cyc, lat);
    check({name, "/busy_cycles"}, nb, lat - 1);
    check({name, "/busy_at_valid"}, busy, 0);
    if (poke_done) begin
      start    = 1'b1;
      alu_ctrl = C_MUL;
      op_a     = 32'd3;
      op_b     = 32'd3;
    end
    @(negedge clk);
    start = 1'b0;
    check({name, "/valid_pulse"}, valid, 0);
    check({name, "/result_hold"}, result, exp);
    if (poke_done) begin
      @(negedge clk);
      check({name, "/done_start_dropped"}, busy, 0);
    end
  endtask

  initial begin
    int          vcount;
    int          bcount;
    logic [5:0]  code;
    logic [31:0] a;
    logic [31:0] b;

    reset    = 1'b0;
    start    = 1'b0;
    alu_ctrl = '0;
    op_a     = '0;
    op_b     = '0;
    #2 reset = 1'b1;
    #1;
    check("reset/busy", busy, 0);
    check("reset/valid", valid, 0);
    check("reset/result", result, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul_7_m3",      C_MUL,    32'd7,          32'hFFFF_FFFD, 0, 0);
    run_op("mulh_min_min",  C_MULH,   32'h8000_0000,  32'h8000_0000, 0, 0);
    run_op("mulhu_max",     C_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0);
    run_op("mulhsu_max",    C_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0);
    run_op("mul_fast_case", C_MUL,    32'd12345,      32'd6789,      0, 0);
    run_op("div_m7_2",      C_DIV,    32'hFFFF_FFF9,  32'd2,         0, 0);
    run_op("rem_m7_2",      C_REM,    32'hFFFF_FFF9,  32'd2,         0, 0);
    run_op("divu_100_7",    C_DIVU,   32'd100,        32'd7,         0, 0);
    run_op("remu_100_7",    C_REMU,   32'd100,        32'd7,         0, 0);
    run_op("div_5_0",       C_DIV,    32'd5,          32'd0,         0, 0);
    run_op("rem_5_0",       C_REM,    32'd5,          32'd0,         0, 0);
    run_op("div_ovf",       C_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 0, 0);
    run_op("rem_ovf",       C_REM,    32'h8000_0000,  32'hFFFF_FFFF, 0, 0);
    run_op("rem_m5_0",      C_REM,    32'hFFFF_FFFB,  32'd0,         0, 0);
    run_op("div_pulse_mid", C_DIVU,   32'hDEAD_BEEF,  32'd1234,      10, 0);
    run_op("done_poke",     C_REMU,   32'd1000,       32'd33,        0, 1);

    // Non-M code: unit must stay idle
    start    = 1'b1;
    alu_ctrl = 6'b000010;
    op_a     = 32'd9;
    op_b     = 32'd4;
    @(negedge clk);
    start  = 1'b0;
    vcount = 0;
    bcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid) vcount++;
      if (busy) bcount++;
      @(negedge clk);
    end
    check("illegal_code/busy_cycles", bcount, 0);
    check("illegal_code/valid_cycles", vcount, 0);

    // Reset in the middle of an iterative divide
    run_op("pre_reset", C_DIVU, 32'd1000, 32'd7, 0, 0);
    start    = 1'b1;
    alu_ctrl = C_DIVU;
    op_a     = 32'hFFFF_0000;
    op_b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_op/busy_before_reset", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_op_reset/busy", busy, 0);
    check("mid_op_reset/valid", valid, 0);
    check("mid_op_reset/result", result, 0);
    @(negedge clk);
    reset  = 1'b0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("mid_op_reset/no_valid", vcount, 0);
    run_op("post_reset", C_DIV, 32'hFFFF_F000, 32'd7, 0, 0);

    // Randomized ops, back to back, biased toward special cases
    for (int i = 0; i < 60; i++) begin
      code = C_MUL | 6'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        3: b = 32'hFFFF_FFFF ^ 32'($urandom_range(0, 3));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), code, a, b, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
